// File: rtl/eco32f_pkg.sv
// Shared constants and types for the eco32f data-side write buffer.
// Wishbone cycle/burst encodings, buffer FSM states and the queued-entry layout.
package eco32f_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_PASS  = 2'd2
    } wbuf_state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wbuf_entry_t;

    localparam int ENTRY_W = $bits(wbuf_entry_t);

endpackage

// File: rtl/eco32f_dwb_wbuf_if.sv
// Wishbone B4 pipelined-less bus bundle; used once for the LSU side and once
// for the system-bus side of the write buffer.
interface eco32f_dwb_wbuf_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output adr, dat_w, sel, cyc, stb, we, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we, cti, bte,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/eco32f_sync_fifo.sv
// Small synchronous FIFO with a combinational head, so the owner can present the
// oldest entry on the bus without an extra read cycle.
module eco32f_sync_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // The extra MSB lets full and empty be told apart when the index bits match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

// File: rtl/eco32f_dwb_wbuf.sv
// Posted-write buffer for the eco32f data Wishbone port: stores are acked at once and
// drained later as single writes; reads wait for the drain, then pass straight through.
module eco32f_dwb_wbuf
    import eco32f_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    eco32f_dwb_wbuf_if.slave        s,
    eco32f_dwb_wbuf_if.master       m,
    output logic                    wbuf_empty,
    output logic                    wbuf_werr
);
    localparam int CW = $clog2(DEPTH) + 1;

    wbuf_state_t r_state;
    wbuf_state_t w_state_next;
    logic        r_ack;
    logic        r_werr;
    logic        r_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    wbuf_entry_t w_head;
    wbuf_entry_t w_wr_entry;

    assign w_wr_entry = '{adr: s.adr, sel: s.sel, dat: s.dat_w};

    // A draining pop frees a slot in the same cycle, so a full buffer can still accept.
    assign w_pop  = (r_state == ST_DRAIN) && (m.ack || m.err);
    assign w_push = s.cyc && s.stb && s.we && !r_ack && (r_state != ST_PASS) &&
                    (!w_full || w_pop);
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

    eco32f_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_wr_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_werr  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_push;
            r_werr  <= (r_state == ST_DRAIN) && m.err && !m.ack;
            r_empty <= (w_count_next == '0) && (w_state_next != ST_DRAIN);
        end
    end

    always_comb begin
        w_state_next = r_state;
        m.adr   = '0;
        m.dat_w = '0;
        m.sel   = '0;
        m.cyc   = 1'b0;
        m.stb   = 1'b0;
        m.we    = 1'b0;
        m.cti   = CTI_CLASSIC;
        m.bte   = BTE_LINEAR;
        s.dat_r = '0;
        s.ack   = r_ack;
        s.err   = 1'b0;
        s.rty   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Queued writes always go first so a following read sees them.
                if (!w_empty)                        w_state_next = ST_DRAIN;
                else if (s.cyc && s.stb && !s.we)    w_state_next = ST_PASS;
            end
            ST_DRAIN: begin
                m.adr   = w_head.adr;
                m.dat_w = w_head.dat;
                m.sel   = w_head.sel;
                m.cyc   = 1'b1;
                m.stb   = 1'b1;
                m.we    = 1'b1;
                m.cti   = CTI_EOB;
                m.bte   = BTE_LINEAR;
                if (m.ack || m.err || m.rty) w_state_next = ST_IDLE;
            end
            ST_PASS: begin
                m.adr   = s.adr;
                m.sel   = s.sel;
                m.cyc   = s.cyc;
                m.stb   = s.stb;
                m.cti   = s.cti;
                m.bte   = s.bte;
                s.dat_r = m.dat_r;
                s.ack   = m.ack;
                s.err   = m.err;
                s.rty   = m.rty;
                if (!s.cyc) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign wbuf_empty = r_empty;
    assign wbuf_werr  = r_werr;
endmodule

// File: tb/tb_eco32f_dwb_wbuf.sv
// Directed bench for the eco32f data-side write buffer: an LSU driver, a scripted
// bus slave (ack / err / rty / silent) and per-scenario tasks with inline checks.
module tb_eco32f_dwb_wbuf;
    import eco32f_pkg::*;

    logic clk;
    logic rst;
    logic wbuf_empty;
    logic wbuf_werr;

    eco32f_dwb_wbuf_if lsu();
    eco32f_dwb_wbuf_if bus();

    eco32f_dwb_wbuf #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (lsu.slave),
        .m          (bus.master),
        .wbuf_empty (wbuf_empty),
        .wbuf_werr  (wbuf_werr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus slave: 0 silent, 1 ack, 2 err, 3 rty -- answers in the same cycle.
    int          slv_mode;
    logic [31:0] slv_rdata;
    assign bus.ack   = (slv_mode == 1) && bus.cyc && bus.stb;
    assign bus.err   = (slv_mode == 2) && bus.cyc && bus.stb;
    assign bus.rty   = (slv_mode == 3) && bus.cyc && bus.stb;
    assign bus.dat_r = slv_rdata;

    logic [31:0] log_adr [$];
    logic [31:0] log_dat [$];
    logic [3:0]  log_sel [$];
    logic [31:0] err_adr [$];
    int          werr_cnt;

    always @(posedge clk) begin
        if (bus.cyc && bus.stb && bus.we && bus.ack) begin
            log_adr.push_back(bus.adr);
            log_dat.push_back(bus.dat_w);
            log_sel.push_back(bus.sel);
        end
        if (bus.cyc && bus.stb && bus.we && bus.err) err_adr.push_back(bus.adr);
        if (wbuf_werr) werr_cnt <= werr_cnt + 1;
    end

    int tests;
    int fails;

    task automatic clear_logs();
        log_adr.delete();
        log_dat.delete();
        log_sel.delete();
        err_adr.delete();
    endtask

    task automatic lsu_idle();
        lsu.cyc = 1'b0; lsu.stb = 1'b0; lsu.we = 1'b0;
        lsu.adr = '0; lsu.dat_w = '0; lsu.sel = '0;
        lsu.cti = CTI_CLASSIC; lsu.bte = BTE_LINEAR;
    endtask

    // Drives one store and returns the number of edges until s_ack_o (0 = none).
    task automatic do_store(input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input int budget, output int lat);
        int w;
        lat = 0;
        @(negedge clk);
        w = 0;
        while (lsu.ack === 1'b1 && w < 4) begin
            @(negedge clk);
            w++;
        end
        lsu.adr = adr; lsu.sel = sel; lsu.dat_w = dat;
        lsu.we = 1'b1; lsu.cyc = 1'b1; lsu.stb = 1'b1;
        lsu.cti = CTI_CLASSIC; lsu.bte = BTE_LINEAR;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (lsu.ack === 1'b1) begin
                lat = c;
                break;
            end
        end
        lsu_idle();
        $display("[TB] store adr=%08h sel=%b dat=%08h ack_latency=%0d", adr, sel, dat, lat);
    endtask

    task automatic wait_empty(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (wbuf_empty === 1'b1 && bus.cyc === 1'b0) break;
        end
    endtask

    task automatic test_reset();
        #7;
        tests++;
        if ({bus.cyc, bus.stb, bus.we, bus.cti, bus.bte} !== 8'h00 || bus.adr !== 32'h0 ||
            bus.dat_w !== 32'h0 || bus.sel !== 4'h0) begin
            fails++;
            $display("FAIL reset_bus: cyc/stb/we=%b%b%b adr=%08h dat=%08h, want all zero",
                     bus.cyc, bus.stb, bus.we, bus.adr, bus.dat_w);
        end
        tests++;
        if ({lsu.ack, lsu.err, lsu.rty, wbuf_werr, wbuf_empty} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_flags: ack/err/rty/werr/empty=%b%b%b%b%b, want 00001",
                     lsu.ack, lsu.err, lsu.rty, wbuf_werr, wbuf_empty);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_store();
        int lat;
        slv_mode = 1;
        clear_logs();
        do_store(32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 4, lat);
        tests++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL single_ack_latency: got %0d, want 1", lat);
        end
        tests++;
        if (wbuf_empty !== 1'b0) begin
            fails++;
            $display("FAIL single_empty_after_push: got %b, want 0", wbuf_empty);
        end
        @(posedge clk); #1;
        tests++;
        if ({bus.cyc, bus.stb, bus.we, bus.cti, bus.bte} !== {3'b111, CTI_EOB, BTE_LINEAR} ||
            bus.adr !== 32'h0000_1000 || bus.sel !== 4'b1111 || bus.dat_w !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL single_bus_write: cyc/stb/we=%b%b%b cti=%b bte=%b adr=%08h sel=%b dat=%08h, want 111 111 00 00001000 1111 deadbeef",
                     bus.cyc, bus.stb, bus.we, bus.cti, bus.bte, bus.adr, bus.sel, bus.dat_w);
        end
        @(posedge clk); #1;
        tests++;
        if (wbuf_empty !== 1'b1 || bus.cyc !== 1'b0 || log_adr.size() != 1) begin
            fails++;
            $display("FAIL single_drained: empty=%b cyc=%b writes=%0d, want 1 0 1",
                     wbuf_empty, bus.cyc, log_adr.size());
        end
    endtask

    task automatic test_five_stores();
        int lat;
        int acked;
        slv_mode = 0;
        clear_logs();
        for (int i = 1; i <= 4; i++) begin
            do_store(32'h0000_2000 + 32'(i * 4), 4'b1111, 32'h1111_0000 + 32'(i), 4, lat);
            tests++;
            if (lat !== 1) begin
                fails++;
                $display("FAIL five_store%0d_ack: latency %0d, want 1", i, lat);
            end
        end
        @(negedge clk);
        while (lsu.ack === 1'b1) @(negedge clk);
        lsu.adr = 32'h0000_2014; lsu.sel = 4'b1111; lsu.dat_w = 32'h1111_0005;
        lsu.we = 1'b1; lsu.cyc = 1'b1; lsu.stb = 1'b1;
        acked = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (lsu.ack === 1'b1) acked++;
        end
        tests++;
        if (acked != 0) begin
            fails++;
            $display("FAIL five_full_no_ack: %0d acks while full, want 0", acked);
        end
        slv_mode = 1;
        @(posedge clk); #1;
        tests++;
        if (lsu.ack !== 1'b1) begin
            fails++;
            $display("FAIL five_store5_ack_on_pop: ack=%b, want 1", lsu.ack);
        end
        $display("[TB] store adr=00002014 sel=1111 dat=11110005 ack_on_first_drain=%b", lsu.ack);
        lsu_idle();
        wait_empty(40);
        tests++;
        if (log_adr.size() != 5 || wbuf_empty !== 1'b1) begin
            fails++;
            $display("FAIL five_drain_count: writes=%0d empty=%b, want 5 1", log_adr.size(), wbuf_empty);
        end
        for (int i = 0; i < 5 && i < log_adr.size(); i++) begin
            tests++;
            if (log_adr[i] !== 32'h0000_2004 + 32'(i * 4) || log_dat[i] !== 32'h1111_0001 + 32'(i) ||
                log_sel[i] !== 4'b1111) begin
                fails++;
                $display("FAIL five_order%0d: adr=%08h dat=%08h, want %08h %08h", i,
                         log_adr[i], log_dat[i], 32'h0000_2004 + 32'(i * 4), 32'h1111_0001 + 32'(i));
            end
        end
    endtask

    task automatic test_store_then_load();
        int lat;
        int bad;
        slv_mode = 0;
        clear_logs();
        do_store(32'h0000_3000, 4'b0011, 32'hCAFE_0001, 4, lat);
        @(negedge clk);
        lsu.adr = 32'hF000_0000; lsu.sel = 4'b1111; lsu.we = 1'b0;
        lsu.cyc = 1'b1; lsu.stb = 1'b1; lsu.cti = CTI_CLASSIC; lsu.bte = BTE_LINEAR;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bus.cyc !== 1'b1 || bus.we !== 1'b1 || bus.adr !== 32'h0000_3000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL load_held_behind_store: %0d cycles without the pending write on the bus, want 0", bad);
        end
        slv_rdata = 32'h1234_5678;
        slv_mode = 1;
        @(posedge clk); #1;
        tests++;
        if (bus.cyc !== 1'b0 || lsu.ack !== 1'b0) begin
            fails++;
            $display("FAIL load_idle_gap: cyc=%b ack=%b, want 0 0", bus.cyc, lsu.ack);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.cyc !== 1'b1 || bus.we !== 1'b0 || bus.adr !== 32'hF000_0000 ||
            lsu.ack !== 1'b1 || lsu.dat_r !== 32'h1234_5678) begin
            fails++;
            $display("FAIL load_pass: cyc=%b we=%b adr=%08h ack=%b dat=%08h, want 1 0 f0000000 1 12345678",
                     bus.cyc, bus.we, bus.adr, lsu.ack, lsu.dat_r);
        end
        $display("[TB] load adr=f0000000 dat=%08h ack=%b", lsu.dat_r, lsu.ack);
        lsu_idle();
        @(posedge clk); #1;
        tests++;
        if (bus.cyc !== 1'b0 || log_adr.size() != 1 || log_adr[0] !== 32'h0000_3000) begin
            fails++;
            $display("FAIL load_end: cyc=%b writes=%0d, want 0 1 (adr 00003000)", bus.cyc, log_adr.size());
        end
    endtask

    task automatic test_refill();
        logic [31:0] exp_adr;
        logic [2:0]  exp_cti;
        int          acks;
        int          bad;
        slv_mode = 1;
        acks = 0;
        bad  = 0;
        @(negedge clk);
        lsu.adr = 32'h0000_4010; lsu.sel = 4'b1111; lsu.we = 1'b0;
        lsu.cyc = 1'b1; lsu.stb = 1'b1; lsu.cti = CTI_INCR; lsu.bte = BTE_WRAP8;
        slv_rdata = 32'hA5A5_0000;
        #1;
        tests++;
        if (bus.cyc !== 1'b0 || lsu.ack !== 1'b0) begin
            fails++;
            $display("FAIL refill_idle_cycle: cyc=%b ack=%b, want 0 0", bus.cyc, lsu.ack);
        end
        @(posedge clk); #1;
        for (int b = 0; b < 8; b++) begin
            exp_adr = 32'h0000_4000 | ((32'h10 + 32'(b * 4)) & 32'h1F);
            exp_cti = (b == 7) ? CTI_EOB : CTI_INCR;
            lsu.adr = exp_adr; lsu.cti = exp_cti;
            slv_rdata = 32'hA5A5_0000 + 32'(b);
            #1;
            if (lsu.ack === 1'b1) acks++;
            tests++;
            if (bus.adr !== exp_adr || bus.cti !== exp_cti || bus.bte !== BTE_WRAP8 ||
                bus.cyc !== 1'b1 || bus.we !== 1'b0 || lsu.ack !== 1'b1 ||
                lsu.dat_r !== 32'hA5A5_0000 + 32'(b)) begin
                fails++;
                bad++;
                $display("FAIL refill_beat%0d: adr=%08h cti=%b bte=%b ack=%b dat=%08h, want %08h %b 10 1 %08h",
                         b, bus.adr, bus.cti, bus.bte, lsu.ack, lsu.dat_r, exp_adr, exp_cti,
                         32'hA5A5_0000 + 32'(b));
            end
            $display("[TB] refill beat=%0d adr=%08h dat=%08h ack=%b", b, bus.adr, lsu.dat_r, lsu.ack);
            @(posedge clk); #1;
        end
        lsu_idle();
        #1;
        tests++;
        if (acks != 8 || bus.cyc !== 1'b0) begin
            fails++;
            $display("FAIL refill_acks: forwarded %0d cyc=%b, want 8 0", acks, bus.cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_err_rty();
        int lat;
        int werr_base;
        clear_logs();
        werr_base = werr_cnt;
        slv_mode = 2;
        do_store(32'h0000_5000, 4'b1111, 32'hBAD0_0001, 4, lat);
        do_store(32'h0000_5004, 4'b1111, 32'h600D_0002, 4, lat);
        tests++;
        if (wbuf_werr !== 1'b1) begin
            fails++;
            $display("FAIL err_pulse: werr=%b, want 1", wbuf_werr);
        end
        slv_mode = 1;
        @(posedge clk); #1;
        tests++;
        if (wbuf_werr !== 1'b0 || bus.cyc !== 1'b1 || bus.adr !== 32'h0000_5004) begin
            fails++;
            $display("FAIL err_next_drain: werr=%b cyc=%b adr=%08h, want 0 1 00005004",
                     wbuf_werr, bus.cyc, bus.adr);
        end
        wait_empty(10);
        tests++;
        if (log_adr.size() != 1 || log_adr[0] !== 32'h0000_5004 || err_adr.size() != 1 ||
            err_adr[0] !== 32'h0000_5000 || werr_cnt - werr_base != 1) begin
            fails++;
            $display("FAIL err_result: writes=%0d errs=%0d werr_cycles=%0d, want 1 1 1",
                     log_adr.size(), err_adr.size(), werr_cnt - werr_base);
        end
        slv_mode = 3;
        clear_logs();
        do_store(32'h0000_6000, 4'b0001, 32'h0000_00AA, 4, lat);
        @(posedge clk); #1;
        tests++;
        if (bus.cyc !== 1'b1 || bus.adr !== 32'h0000_6000 || bus.rty !== 1'b1) begin
            fails++;
            $display("FAIL rty_first: cyc=%b adr=%08h rty=%b, want 1 00006000 1", bus.cyc, bus.adr, bus.rty);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.cyc !== 1'b0 || wbuf_empty !== 1'b0) begin
            fails++;
            $display("FAIL rty_gap: cyc=%b empty=%b, want 0 0", bus.cyc, wbuf_empty);
        end
        slv_mode = 1;
        @(posedge clk); #1;
        tests++;
        if (bus.cyc !== 1'b1 || bus.adr !== 32'h0000_6000 || bus.dat_w !== 32'h0000_00AA) begin
            fails++;
            $display("FAIL rty_reissue: cyc=%b adr=%08h dat=%08h, want 1 00006000 000000aa",
                     bus.cyc, bus.adr, bus.dat_w);
        end
        @(posedge clk); #1;
        tests++;
        if (wbuf_empty !== 1'b1 || log_adr.size() != 1) begin
            fails++;
            $display("FAIL rty_done: empty=%b writes=%0d, want 1 1", wbuf_empty, log_adr.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        int lat;
        int seen;
        slv_mode = 0;
        clear_logs();
        for (int i = 0; i < 3; i++)
            do_store(32'h0000_7000 + 32'(i * 4), 4'b1111, 32'h7777_0000 + 32'(i), 4, lat);
        tests++;
        if (bus.cyc !== 1'b1 || bus.adr !== 32'h0000_7000 || lsu.ack !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre: cyc=%b adr=%08h ack=%b, want 1 00007000 1", bus.cyc, bus.adr, lsu.ack);
        end
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.cyc, bus.stb, bus.we} !== 3'b000 || bus.adr !== 32'h0 ||
            {lsu.ack, wbuf_werr, wbuf_empty} !== 3'b001) begin
            fails++;
            $display("FAIL rst_async: cyc/stb/we=%b%b%b adr=%08h ack/werr/empty=%b%b%b, want 000 0 001",
                     bus.cyc, bus.stb, bus.we, bus.adr, lsu.ack, wbuf_werr, wbuf_empty);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        slv_mode = 1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.cyc !== 1'b0 || wbuf_empty !== 1'b1) seen++;
        end
        tests++;
        if (seen != 0 || log_adr.size() != 0) begin
            fails++;
            $display("FAIL rst_fifo_lost: %0d busy cycles, %0d writes after reset, want 0 0", seen, log_adr.size());
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        werr_cnt  = 0;
        slv_mode  = 0;
        slv_rdata = '0;
        rst       = 1'b1;
        lsu_idle();
        test_reset();
        test_single_store();
        test_five_stores();
        test_store_then_load();
        test_refill();
        test_err_rty();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion before 200000");
        $fatal(1, "watchdog");
    end
endmodule
